// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and AER event type for the LIF neuron array
package lif_pkg;
    localparam int N_NEURONS     = 8;
    localparam int ID_W          = 3;
    localparam int TS_W          = 8;
    localparam int FIFO_DEPTH    = 4;
    localparam int DROP_W        = 8;
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;
    localparam int LIF_THRESHOLD = 200;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
    } aer_evt_t;
endpackage

// File: rtl/lif_spike_encoder_if.sv
// rtl/lif_spike_encoder_if.sv - valid/ready AER event stream
interface lif_spike_encoder_if;
    logic                     evt_valid;
    logic                     evt_ready;
    logic [lif_pkg::ID_W-1:0] evt_id;
    logic [lif_pkg::TS_W-1:0] evt_ts;

    modport master (output evt_valid, evt_id, evt_ts, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_ts, output evt_ready);
endinterface

// File: rtl/lif_evt_fifo.sv
// rtl/lif_evt_fifo.sv - first-word fall-through FIFO of AER events
module lif_evt_fifo
    import lif_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  aer_evt_t               push_data,
    input  logic                   pop,
    output aer_evt_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    aer_evt_t         mem_q [DEPTH];
    aer_evt_t         mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/lif_spike_encoder.sv
// rtl/lif_spike_encoder.sv - serialises neuron spikes into timestamped AER events
module lif_spike_encoder
    import lif_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_NEURONS-1:0]   spike_in,
    lif_spike_encoder_if.master    evt,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);
    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic                 overflow_q, overflow_d;
    logic [DROP_W-1:0]    drop_q, drop_d;

    logic [N_NEURONS-1:0] grant_vec, spike_en;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any, can_push, drop_any, pop;
    logic                 full, empty;
    aer_evt_t             head, wr_evt;

    assign pop           = evt.evt_valid && evt.evt_ready;
    assign evt.evt_valid = !empty;
    assign evt.evt_id    = head.id;
    assign evt.evt_ts    = head.ts;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;
    assign wr_evt        = '{id: grant_id, ts: ts_q};

    always_comb begin
        grant_id  = '0;
        can_push  = !full || pop;
        // Descending scan so the lowest-index pending neuron wins.
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_id = ID_W'(i);
            end
        end
        grant_any  = can_push && (|pending_q);
        grant_vec  = grant_any ? (N_NEURONS'(1) << grant_id) : '0;
        spike_en   = spike_in & {N_NEURONS{enable}};
        drop_any   = |(spike_en & pending_q & ~grant_vec);
        pending_d  = (pending_q & ~grant_vec) | spike_en;
        ts_d       = enable ? ts_q + 1'b1 : ts_q;
        overflow_d = overflow_q | drop_any;
        drop_d     = (drop_any && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    lif_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_any),
        .push_data (wr_evt),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_lif_spike_encoder.sv
// tb/tb_lif_spike_encoder.sv - directed self-checking bench for lif_spike_encoder
module tb_lif_spike_encoder;
    import lif_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic [N_NEURONS-1:0] spike_in = '0;
    logic [CNT_W-1:0]     fifo_count;
    logic                 overflow;
    logic [DROP_W-1:0]    drop_count;
    logic [TS_W-1:0]      ts_exp = '0;
    int                   errors = 0;
    int                   checks = 0;

    lif_spike_encoder_if evt_if ();

    lif_spike_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .evt        (evt_if),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // One active edge; ts_exp follows the timestamp register.
    task automatic tick();
        @(posedge clk);
        if (enable) ts_exp = ts_exp + 8'd1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        enable = 1'b0;
        reset  = 1'b1;
        #2;
        reset  = 1'b0;
        ts_exp = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        evt_if.evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        ts_exp = '0;
        enable = 1'b1;
        spike_in = 8'h07;
        tick();
        tick();
        spike_in = 8'h00;
        tick();
        tick();
        checks++;
        if (fifo_count !== 3'd3 || overflow !== 1'b1 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_prefill: count=%0d ovf=%0d drops=%0d want 3 1 1", fifo_count, overflow, drop_count);
        end
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        checks++;
        if (evt_if.evt_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo: valid=%0d count=%0d want 0 0", evt_if.evt_valid, fifo_count);
        end
        checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop: ovf=%0d drops=%0d want 0 0", overflow, drop_count);
        end
        checks++;
        if (evt_if.evt_id !== 3'd0 || evt_if.evt_ts !== 8'd0) begin
            errors++;
            $display("FAIL reset_head: id=%0d ts=%0d want 0 0", evt_if.evt_id, evt_if.evt_ts);
        end
        #1;
        reset  = 1'b0;
        ts_exp = '0;
        repeat (3) tick();
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending_cleared: valid=%0d want 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_single();
        enable = 1'b1;
        evt_if.evt_ready = 1'b1;
        repeat (6) tick();
        // Spike sampled at the edge taking ts 6->7; written at ts 7.
        spike_in = 8'h10;
        tick();
        spike_in = 8'h00;
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle1: valid=%0d want 0", evt_if.evt_valid);
        end
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd4 || evt_if.evt_ts !== 8'd7) begin
            errors++;
            $display("FAIL single_cycle2: valid=%0d id=%0d ts=%0d want 1 4 7", evt_if.evt_valid, evt_if.evt_id, evt_if.evt_ts);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (evt_if.evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_no_extra: cycle %0d valid=%0d want 0", i, evt_if.evt_valid);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] ids [3];
        logic [TS_W-1:0] t0;
        ids[0] = 3'd0; ids[1] = 3'd2; ids[2] = 3'd7;
        evt_if.evt_ready = 1'b1;
        t0 = ts_exp;
        spike_in = 8'b1000_0101;
        tick();
        spike_in = 8'h00;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== ids[k] || evt_if.evt_ts !== t0 + 8'(k + 1)) begin
                errors++;
                $display("FAIL simul_evt%0d: valid=%0d id=%0d ts=%0d want 1 %0d %0d",
                         k, evt_if.evt_valid, evt_if.evt_id, evt_if.evt_ts, ids[k], t0 + 8'(k + 1));
            end
            tick();
        end
        checks++;
        if (evt_if.evt_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_end: valid=%0d ovf=%0d want 0 0", evt_if.evt_valid, overflow);
        end
    endtask

    task automatic test_back_pressure();
        evt_if.evt_ready = 1'b0;
        spike_in = 8'hFF;
        tick();
        spike_in = 8'h00;
        repeat (4) tick();
        checks++;
        if (fifo_count !== 3'd4 || evt_if.evt_id !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: count=%0d id=%0d ovf=%0d want 4 0 0", fifo_count, evt_if.evt_id, overflow);
        end
        // Neurons 4..7 are still pending, so every further spike on them is lost.
        spike_in = 8'hF0;
        repeat (5) tick();
        spike_in = 8'h00;
        checks++;
        if (drop_count !== 8'd5 || overflow !== 1'b1 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_drops: drops=%0d ovf=%0d count=%0d want 5 1 4", drop_count, overflow, fifo_count);
        end
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'(k)) begin
                errors++;
                $display("FAIL bp_order%0d: valid=%0d id=%0d want 1 %0d", k, evt_if.evt_valid, evt_if.evt_id, k);
            end
            if (k == 1) begin
                checks++;
                if (fifo_count !== 3'd4) begin
                    errors++;
                    $display("FAIL bp_full_pushpop: count=%0d want 4", fifo_count);
                end
            end
            tick();
        end
        checks++;
        if (evt_if.evt_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_end: valid=%0d ovf=%0d want 0 1", evt_if.evt_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [2:0] ids [4];
        ids[0] = 3'd1; ids[1] = 3'd2; ids[2] = 3'd3; ids[3] = 3'd5;
        evt_if.evt_ready = 1'b0;
        spike_in = 8'h2F;
        tick();
        spike_in = 8'h00;
        repeat (4) tick();
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || evt_if.evt_id !== 3'd1) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d head=%0d want 4 1", fifo_count, evt_if.evt_id);
        end
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== ids[k]) begin
                errors++;
                $display("FAIL full_drain%0d: valid=%0d id=%0d want 1 %0d", k, evt_if.evt_valid, evt_if.evt_id, ids[k]);
            end
            tick();
        end
        checks++;
        if (evt_if.evt_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL full_drained: valid=%0d count=%0d want 0 0", evt_if.evt_valid, fifo_count);
        end
    endtask

    task automatic test_wrap_enable();
        logic [TS_W-1:0] t_held;
        apply_reset();
        enable = 1'b1;
        evt_if.evt_ready = 1'b1;
        repeat (255) tick();
        spike_in = 8'h02;
        tick();
        spike_in = 8'h00;
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd1 || evt_if.evt_ts !== 8'd0) begin
            errors++;
            $display("FAIL wrap_ts: valid=%0d id=%0d ts=%0d want 1 1 0", evt_if.evt_valid, evt_if.evt_id, evt_if.evt_ts);
        end
        tick();
        spike_in = 8'h02;
        tick();
        t_held = ts_exp;
        enable = 1'b0;
        spike_in = 8'h00;
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd1 || evt_if.evt_ts !== t_held) begin
            errors++;
            $display("FAIL disabled_drain: valid=%0d id=%0d ts=%0d want 1 1 %0d", evt_if.evt_valid, evt_if.evt_id, evt_if.evt_ts, t_held);
        end
        spike_in = 8'hFF;
        repeat (3) tick();
        spike_in = 8'h00;
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL disabled_ignore: valid=%0d ovf=%0d want 0 0", evt_if.evt_valid, overflow);
        end
        enable = 1'b1;
        spike_in = 8'h01;
        tick();
        spike_in = 8'h00;
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd0 || evt_if.evt_ts !== t_held + 8'd1) begin
            errors++;
            $display("FAIL ts_held: valid=%0d id=%0d ts=%0d want 1 0 %0d", evt_if.evt_valid, evt_if.evt_id, evt_if.evt_ts, t_held + 8'd1);
        end
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_back_pressure();
        test_full_push_pop();
        test_wrap_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
